// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through read stage of the async FIFO (rd_clk domain).
// Issues read increments on credit, captures RAM data and presents it through a 2-entry head/skid buffer.
module fifo_rd_fwft #(
   parameter int data_width = 8
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  empty,
   output logic                  rd_inc,
   input  logic [data_width-1:0] mem_rdata,
   output logic [data_width-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [1:0]            buf_occ
);

   // Handshake: a word transfers on any rd_clk edge where rd_valid & rd_ready;
   // rd_valid never drops and rd_data never changes until that transfer happens.

   typedef enum logic [1:0] {
      OCC0 = 2'd0,
      OCC1 = 2'd1,
      OCC2 = 2'd2
   } occ_t;

   occ_t                  state;
   occ_t                  state_nxt;
   logic                  inflight;
   logic [data_width-1:0] head;
   logic [data_width-1:0] skid;
   logic                  head_ld;
   logic                  head_from_skid;
   logic                  skid_ld;
   logic                  push;
   logic                  pop;
   logic [2:0]            credit_sum;

   assign push     = inflight;
   assign pop      = rd_valid & rd_ready;
   assign rd_valid = (state != OCC0);
   assign rd_data  = head;
   assign buf_occ  = state;

   // Words held plus the one already requested from RAM must fit in two entries.
   assign credit_sum = {1'b0, buf_occ} + {2'b00, inflight} - {2'b00, pop};
   assign rd_inc     = ~rd_rst & ~empty & (credit_sum < 3'd2);

   always_comb begin
      state_nxt      = state;
      head_ld        = 1'b0;
      head_from_skid = 1'b0;
      skid_ld        = 1'b0;
      case (state)
         OCC0: begin
            if (push) begin
               state_nxt = OCC1;
               head_ld   = 1'b1;
            end
         end
         OCC1: begin
            if (push && !pop) begin
               state_nxt = OCC2;
               skid_ld   = 1'b1;
            end else if (push && pop) begin
               head_ld = 1'b1;
            end else if (pop) begin
               state_nxt = OCC0;
            end
         end
         OCC2: begin
            if (pop) begin
               state_nxt      = OCC1;
               head_from_skid = 1'b1;
            end
         end
         default: state_nxt = OCC0;
      endcase
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state    <= OCC0;
         inflight <= 1'b0;
         head     <= '0;
         skid     <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= rd_inc;
         if (head_ld)
            head <= mem_rdata;
         else if (head_from_skid)
            head <= skid;
         if (skid_ld)
            skid <= mem_rdata;
      end
   end

endmodule
